// File: rtl/slc3_fetch_prefetch_if.sv
// rtl/slc3_fetch_prefetch_if.sv - memory read port between the fetch unit and the memory controller
interface slc3_fetch_prefetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/slc3_fetch_prefetch.sv
// rtl/slc3_fetch_prefetch.sv - SLC-3 instruction fetch with prefetch queue, redirect and single-step
module slc3_fetch_prefetch #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  Continue,
  input  logic                  step_mode,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  input  logic                  ir_take,
  slc3_fetch_prefetch_if.master mem,
  output logic [ADDR_W-1:0]     PC,
  output logic [ADDR_W-1:0]     MAR,
  output logic [DATA_W-1:0]     MDR,
  output logic [DATA_W-1:0]     IR,
  output logic [ADDR_W-1:0]     ir_pc,
  output logic                  ir_valid,
  output logic                  halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // IDLE: no read in flight. FETCH: read in flight, still prefetching.
  // DRAIN: read in flight but no further issue (Run low or queue full).
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_after;

  logic discard;
  logic credit, credit_n;
  logic run_q, cont_q;
  logic halted_n;

  logic outstanding, completing, push, take, step_block, load, issue, out_n;
  logic run_rise, cont_rise;

  // A read is in flight exactly when the FSM is not idle; MAR is the bus address.
  assign outstanding  = (state != IDLE);
  assign mem.mem_rd   = outstanding;
  assign mem.mem_addr = MAR;

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_n     = state;
    completing  = 1'b0;
    push        = 1'b0;
    take        = 1'b0;
    step_block  = 1'b0;
    load        = 1'b0;
    issue       = 1'b0;
    out_n       = 1'b0;
    run_rise    = 1'b0;
    cont_rise   = 1'b0;
    credit_n    = credit;
    halted_n    = 1'b0;
    count_after = count;

    completing = outstanding && mem.mem_ready;
    // Data from a read issued before a redirect is stale and never enters the queue.
    push       = completing && !discard && !redirect_valid;
    take       = ir_take && ir_valid;
    step_block = step_mode && !credit;
    load       = (count != '0) && (!ir_valid || take) && !step_block && !redirect_valid;

    count_after = count + CNT_W'(push) - CNT_W'(load);

    // The new read must still fit once everything already fetched is queued.
    issue = Run && !redirect_valid && (!outstanding || mem.mem_ready) &&
            (count_after < DEPTH_C);

    out_n = issue || (outstanding && !mem.mem_ready);
    if (!out_n)
      state_n = IDLE;
    else if (Run && (count_after != DEPTH_C))
      state_n = FETCH;
    else
      state_n = DRAIN;

    run_rise  = Run && !run_q;
    cont_rise = Continue && !cont_q;
    if (run_rise || cont_rise)
      credit_n = 1'b1;
    else if (load)
      credit_n = 1'b0;

    halted_n = step_mode && Run && !credit_n;
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Queue storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge Clk) begin
    if (!Reset && push) begin
      q_addr[wr_ptr] <= MAR;
      q_data[wr_ptr] <= mem.mem_rdata;
    end
  end

  // PC/MAR/MDR, queue pointers, IR slot and step-mode bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC       <= RESET_PC;
      MAR      <= '0;
      MDR      <= '0;
      IR       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      discard  <= 1'b0;
      credit   <= 1'b0;
      run_q    <= 1'b0;
      cont_q   <= 1'b0;
    end else begin
      run_q  <= Run;
      cont_q <= Continue;
      credit <= credit_n;
      halted <= halted_n;

      if (redirect_valid)
        PC <= redirect_pc;
      else if (issue)
        PC <= PC + ADDR_W'(1);

      if (issue)
        MAR <= PC;

      if (completing)
        MDR <= mem.mem_rdata;

      if (completing)
        discard <= 1'b0;
      else if (redirect_valid && outstanding)
        discard <= 1'b1;

      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (load)
          rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_after;
      end

      if (redirect_valid) begin
        ir_valid <= 1'b0;
      end else if (load) begin
        IR       <= q_data[rd_ptr];
        ir_pc    <= q_addr[rd_ptr];
        ir_valid <= 1'b1;
      end else if (take) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slc3_fetch_prefetch.sv
// tb/tb_slc3_fetch_prefetch.sv - scoreboard bench for slc3_fetch_prefetch
module tb_slc3_fetch_prefetch;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // DUT 1: default parameters
  logic        rst, run, cont, step_mode, redir_v, ir_take;
  logic [15:0] redir_pc;
  logic [15:0] pc, mar, mdr, ir, ir_pc;
  logic        ir_valid, halted;
  slc3_fetch_prefetch_if #(.DATA_W(16), .ADDR_W(16)) mif ();

  slc3_fetch_prefetch #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .Clk(clk), .Reset(rst), .Run(run), .Continue(cont), .step_mode(step_mode),
    .redirect_valid(redir_v), .redirect_pc(redir_pc), .ir_take(ir_take), .mem(mif),
    .PC(pc), .MAR(mar), .MDR(mdr), .IR(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted)
  );

  // DUT 2: reset PC near the top of the address space
  logic        rst2, run2;
  logic [15:0] pc2, mar2, mdr2, ir2, ir_pc2;
  logic        ir_valid2, halted2;
  slc3_fetch_prefetch_if #(.DATA_W(16), .ADDR_W(16)) mif2 ();

  slc3_fetch_prefetch #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'hFFFE)) dut2 (
    .Clk(clk), .Reset(rst2), .Run(run2), .Continue(1'b0), .step_mode(1'b0),
    .redirect_valid(1'b0), .redirect_pc(16'h0000), .ir_take(1'b0), .mem(mif2),
    .PC(pc2), .MAR(mar2), .MDR(mdr2), .IR(ir2), .ir_pc(ir_pc2), .ir_valid(ir_valid2), .halted(halted2)
  );

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int busy   = 0;

  logic [31:0] exp_ir_q [$];
  logic [15:0] exp_a2_q [$];
  logic [31:0] exp_ir_e;
  logic [15:0] exp_a2_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Memory model for DUT 1: mem[a] = 0x1000 + a, wait_n wait cycles per read.
  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (mif.mem_rd) begin
        if (busy == wait_n) begin
          mif.mem_ready = 1'b1;
          mif.mem_rdata = 16'h1000 + mif.mem_addr;
          busy = 0;
        end else begin
          mif.mem_ready = 1'b0;
          busy++;
        end
      end else begin
        mif.mem_ready = 1'b0;
        busy = 0;
      end
    end
  end

  // Memory model for DUT 2: zero-wait.
  initial begin
    mif2.mem_ready = 1'b0;
    mif2.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      mif2.mem_ready = mif2.mem_rd;
      mif2.mem_rdata = 16'h1000 + mif2.mem_addr;
    end
  end

  // Monitor: every instruction consumed by decode is compared with the scoreboard.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst && ir_valid && ir_take) begin
      if (exp_ir_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ir_deliver: got unexpected %h expected none", {ir_pc, ir});
      end else begin
        exp_ir_e = exp_ir_q.pop_front();
        chk("ir_deliver", {ir_pc, ir}, exp_ir_e);
      end
    end
  end

  // Monitor: every completed read of DUT 2 is compared with the address scoreboard.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst2 && mif2.mem_rd && mif2.mem_ready) begin
      if (exp_a2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL addr2: got unexpected %h expected none", mif2.mem_addr);
      end else begin
        exp_a2_e = exp_a2_q.pop_front();
        chk("addr2", 32'(mif2.mem_addr), 32'(exp_a2_e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    ir_take   = 1'b0;
    run       = 1'b0;
    cont      = 1'b0;
    step_mode = 1'b0;
    redir_v   = 1'b0;
    redir_pc  = 16'h0000;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; run = 1'b0; run2 = 1'b0; cont = 1'b0; step_mode = 1'b0;
    redir_v = 1'b0; redir_pc = 16'h0000; ir_take = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0; rst2 = 1'b0;

    // Reset values
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_mar", 32'(mar), 32'h0000);
    chk("rst_mdr", 32'(mdr), 32'h0000);
    chk("rst_ir", 32'(ir), 32'h0000);
    chk("rst_ir_pc", 32'(ir_pc), 32'h0000);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_mem_rd", 32'(mif.mem_rd), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst2_pc", 32'(pc2), 32'hFFFE);

    // PC wrap: DUT 2 fetches FFFE, FFFF, 0000, 0001, 0002 and then the queue is full
    exp_a2_q.push_back(16'hFFFE); exp_a2_q.push_back(16'hFFFF); exp_a2_q.push_back(16'h0000);
    exp_a2_q.push_back(16'h0001); exp_a2_q.push_back(16'h0002);
    run2 = 1'b1;
    step();
    chk("wrap_first_addr", 32'(mif2.mem_addr), 32'hFFFE);
    repeat (11) step();
    chk("wrap_ir", 32'(ir2), 32'h0FFE);
    chk("wrap_ir_pc", 32'(ir_pc2), 32'hFFFE);
    chk("wrap_pc", 32'(pc2), 32'h0003);
    chk("wrap_mem_rd", 32'(mif2.mem_rd), 0);

    // Streaming: zero-wait memory, decode always taking
    do_reset();
    wait_n = 0;
    for (int a = 0; a < 6; a++) exp_ir_q.push_back({16'(a), 16'h1000 + 16'(a)});
    ir_take = 1'b1;
    run = 1'b1;
    step();
    chk("s1_k_mem_rd", 32'(mif.mem_rd), 1);
    chk("s1_k_addr", 32'(mif.mem_addr), 32'h0000);
    step();
    chk("s1_k1_ir_valid", 32'(ir_valid), 0);
    chk("s1_k1_mdr", 32'(mdr), 32'h1000);
    step();
    chk("s1_k2_ir_valid", 32'(ir_valid), 1);
    chk("s1_k2_ir", 32'(ir), 32'h1000);
    chk("s1_k2_ir_pc", 32'(ir_pc), 32'h0000);
    step();
    chk("s1_k3_ir", 32'(ir), 32'h1001);
    chk("s1_k3_addr", 32'(mif.mem_addr), 32'h0003);
    step();
    chk("s1_k4_ir", 32'(ir), 32'h1002);
    chk("s1_k4_ir_pc", 32'(ir_pc), 32'h0002);
    step();
    run = 1'b0;
    repeat (8) step();
    chk("s1_end_pc", 32'(pc), 32'h0006);
    chk("s1_end_ir", 32'(ir), 32'h1005);
    chk("s1_end_ir_valid", 32'(ir_valid), 0);
    chk("s1_end_mem_rd", 32'(mif.mem_rd), 0);

    // Single-step mode
    do_reset();
    exp_ir_q.push_back({16'h0000, 16'h1000});
    exp_ir_q.push_back({16'h0001, 16'h1001});
    step_mode = 1'b1;
    ir_take = 1'b1;
    run = 1'b1;
    step();
    chk("s2_k_halted", 32'(halted), 0);
    step();
    step();
    chk("s2_k2_ir", 32'(ir), 32'h1000);
    chk("s2_k2_halted", 32'(halted), 1);
    repeat (6) step();
    chk("s2_wait_ir", 32'(ir), 32'h1000);
    chk("s2_wait_halted", 32'(halted), 1);
    chk("s2_wait_pc", 32'(pc), 32'h0005);
    chk("s2_wait_mem_rd", 32'(mif.mem_rd), 0);
    cont = 1'b1;
    step();
    chk("s2_c_halted", 32'(halted), 0);
    chk("s2_c_ir", 32'(ir), 32'h1000);
    step();
    chk("s2_c1_ir", 32'(ir), 32'h1001);
    chk("s2_c1_ir_pc", 32'(ir_pc), 32'h0001);
    chk("s2_c1_halted", 32'(halted), 1);
    repeat (3) step();
    cont = 1'b0;
    repeat (4) step();
    chk("s2_end_ir", 32'(ir), 32'h1001);
    chk("s2_end_halted", 32'(halted), 1);
    chk("s2_end_pc", 32'(pc), 32'h0006);

    // Backpressure: decode not taking, queue fills
    do_reset();
    run = 1'b1;
    repeat (10) step();
    chk("s3_mem_rd", 32'(mif.mem_rd), 0);
    chk("s3_pc", 32'(pc), 32'h0005);
    chk("s3_ir_valid", 32'(ir_valid), 1);
    chk("s3_ir", 32'(ir), 32'h1000);
    chk("s3_mdr", 32'(mdr), 32'h1004);
    exp_ir_q.push_back({16'h0000, 16'h1000});
    ir_take = 1'b1;
    step();
    ir_take = 1'b0;
    chk("s3_t_ir", 32'(ir), 32'h1001);
    chk("s3_t_mem_rd", 32'(mif.mem_rd), 1);
    chk("s3_t_addr", 32'(mif.mem_addr), 32'h0005);
    step();
    chk("s3_t1_mem_rd", 32'(mif.mem_rd), 0);
    chk("s3_t1_pc", 32'(pc), 32'h0006);
    chk("s3_t1_mdr", 32'(mdr), 32'h1005);

    // Redirect while a slow read is outstanding
    do_reset();
    wait_n = 3;
    ir_take = 1'b1;
    run = 1'b1;
    step();
    chk("s4_k_addr", 32'(mif.mem_addr), 32'h0000);
    step();
    redir_v = 1'b1;
    redir_pc = 16'h0040;
    step();
    redir_v = 1'b0;
    chk("s4_r_pc", 32'(pc), 32'h0040);
    chk("s4_r_mem_rd", 32'(mif.mem_rd), 1);
    chk("s4_r_addr", 32'(mif.mem_addr), 32'h0000);
    step();
    chk("s4_k3_mdr", 32'(mdr), 32'h0000);
    step();
    chk("s4_k4_mdr", 32'(mdr), 32'h1000);
    chk("s4_k4_ir_valid", 32'(ir_valid), 0);
    chk("s4_k4_addr", 32'(mif.mem_addr), 32'h0040);
    chk("s4_k4_mem_rd", 32'(mif.mem_rd), 1);
    chk("s4_k4_pc", 32'(pc), 32'h0041);
    exp_ir_q.push_back({16'h0040, 16'h1040});
    run = 1'b0;
    repeat (8) step();
    chk("s4_end_ir", 32'(ir), 32'h1040);
    chk("s4_end_ir_pc", 32'(ir_pc), 32'h0040);
    chk("s4_end_mem_rd", 32'(mif.mem_rd), 0);
    chk("s4_end_pc", 32'(pc), 32'h0041);

    // Reset while a read is outstanding
    do_reset();
    wait_n = 3;
    run = 1'b1;
    step();
    chk("s5_mem_rd", 32'(mif.mem_rd), 1);
    rst = 1'b1;
    step();
    chk("s5_rst_mem_rd", 32'(mif.mem_rd), 0);
    chk("s5_rst_pc", 32'(pc), 32'h0000);
    chk("s5_rst_mar", 32'(mar), 32'h0000);
    chk("s5_rst_ir_valid", 32'(ir_valid), 0);
    chk("s5_rst_halted", 32'(halted), 0);
    rst = 1'b0;
    step();
    chk("s5_restart_mem_rd", 32'(mif.mem_rd), 1);
    chk("s5_restart_addr", 32'(mif.mem_addr), 32'h0000);
    chk("s5_restart_pc", 32'(pc), 32'h0001);

    do_reset();
    repeat (2) step();
    chk("ir_scoreboard_empty", 32'(exp_ir_q.size()), 0);
    chk("addr2_scoreboard_empty", 32'(exp_a2_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slc3_fetch_prefetch.md
# slc3_fetch_prefetch

Parametrised instruction-fetch unit for the SLC-3 datapath, succeeding the fixed single-instruction fetch with its PC, MAR, MDR and IR registers. It keeps a DEPTH-entry prefetch queue between memory and IR. It adds a memory ready handshake, decode backpressure, PC redirect with flush, and a selectable single-step mode. It sits between the SRAM/memory controller and the decode/execute control in the CPU top level.

## Interface
- DATA_W, 16, instruction/data width
- ADDR_W, 16, address width; PC wraps modulo 2^ADDR_W
- DEPTH, 4, prefetch queue entries (power of 2, ≥2)
- RESET_PC, 0, PC value after reset
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- Run  in  1  level; 1 = fetch enabled
- Continue  in  1  level; rising edge (internally detected) grants one step in step mode
- step_mode  in  1  1 = halt after each IR load until Continue edge
- redirect_valid  in  1  load PC from redirect_pc and flush
- redirect_pc  in  ADDR_W  new fetch address
- ir_take  in  1  decode consumed current IR (ignored when ir_valid=0)
- mem_rd  out  1  read request
- mem_addr  out  ADDR_W  read address (= MAR)
- mem_ready  in  1  read completes this cycle; mem_rdata valid
- mem_rdata  in  DATA_W  read data
- PC, MAR  out  ADDR_W  next fetch address; address of last issued read
- MDR  out  DATA_W  last data returned by memory
- IR  out  DATA_W  current instruction
- ir_pc  out  ADDR_W  address of IR
- ir_valid  out  1  IR holds an undelivered instruction
- halted  out  1  step mode waiting for Continue

## Operation
- States: IDLE, FETCH (mem_rd high, awaiting mem_ready), DRAIN (Run low or queue full, outstanding read pending).
- Issue: when Run=1, no outstanding read, and queue_count + ir_slot_pending < DEPTH: mem_rd=1, MAR<=PC, PC<=PC+1. mem_rd and mem_addr held stable until mem_ready=1. One outstanding read max.
- Completion: on mem_ready, MDR<=mem_rdata; push {MAR, mem_rdata} unless discard flag set (then clear flag, no push).
- IR load: at an edge where queue non-empty, (ir_valid=0 or ir_take=1), and not step-blocked: IR/ir_pc<=head, pop, ir_valid<=1. If ir_take=1 and queue empty: ir_valid<=0.
- Step mode: credit set on Run rising into FETCH and on each Continue rising edge; IR load consumes credit; with no credit, halted=1 and IR holds; prefetch continues filling queue.
- Redirect (priority over all but Reset): PC<=redirect_pc, queue cleared, ir_valid<=0; if read outstanding, set discard flag and keep mem_rd asserted until its mem_ready.
- Run low: no new issue; outstanding read completes; then IDLE. Queue/IR retained; Run high resumes at PC.
- Queue never overflows (issue gating counts outstanding read); simultaneous push and pop allowed.

## Timing
- Reset values: PC=RESET_PC, MAR=0, MDR=0, IR=0, ir_pc=0, ir_valid=0, mem_rd=0, halted=0, queue empty, discard=0, credit=0, state IDLE. Reset mid-read abandons it; memory must tolerate a dropped request.
- Run sampled high at edge k: mem_rd=1, mem_addr=PC after edge k. Zero-wait mem_ready: push at k+1, IR valid after k+2.
- Zero-wait memory, ir_take=1: one instruction per cycle steady state; mem_rd stays high with consecutive addresses.
- Redirect at edge r with no outstanding read: mem_addr=redirect_pc after edge r+1 (issue cycle).
- Continue edge at edge c: IR loads at c+1 if queue non-empty.

## Test plan
- Run=1, step_mode=0, ir_take=1, zero-wait mem[a]=0x1000+a -> IR 0x1000,0x1001,0x1002 on consecutive cycles, first 2 edges after Run; ir_pc 0,1,2.
- step_mode=1, Continue held high 5 cycles -> IR advances exactly once (0x1000->0x1001); halted=1 otherwise.
- ir_take=0, DEPTH=4 -> addresses 0..4 fetched, then mem_rd=0, PC=5, ir_valid=1, IR=0x1000; ir_take pulse -> one new fetch at 5.
- mem_ready 3 cycles late, redirect_pc=0x0040 during wait -> stale data in MDR only, not IR; next mem_addr=0x0040; IR=0x1040.
- RESET_PC=0xFFFE -> fetch addresses 0xFFFE, 0xFFFF, 0x0000.
- Reset asserted while mem_rd=1 -> next edge all outputs at reset values, mem_rd=0; Run restarts at RESET_PC.
